glitch_detector: RTL and testbench

- Lockstep comparator downstream of the glitch injector in the dual-core path.
- Compares the primary core word (data_a) against the shadow word (data_b), which passes through the injector.
- Core B runs DELAY cycles behind core A, so data_a/valid_a are delayed internally by DELAY cycles before comparison.
- Classifies divergence through a three-state FSM and raises a sticky fault for the core-reset/recovery logic.

---
 rtl/glitch_pkg.sv | 16 +
 rtl/delay_line.sv | 32 +++
 rtl/glitch_detector.sv | 136 +++++++++++++
 tb/tb_glitch_detector.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/glitch_pkg.sv
// Types and constants shared by the lockstep glitch injector and detector.
package glitch_pkg;

  typedef enum logic [1:0] {
    StOk      = 2'd0,
    StSuspect = 2'd1,
    StFault   = 2'd2
  } state_e;

  localparam int unsigned DefaultWidth = 8;

  // Reference stream patterns used by the injector and its benches.
  localparam logic [7:0] PatIdle = 8'hAA;
  localparam logic [7:0] PatFlip = 8'h55;

endpackage

// File: rtl/delay_line.sv
// Fixed-latency register pipeline with synchronous active-low reset.
// DELAY=0 is a wire.
module delay_line #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DELAY = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DELAY == 0) begin : g_bypass
    logic unused_clk_rst;
    assign unused_clk_rst = ^{clk, reset};
    assign dout = din;
  end else begin : g_pipe
    logic [WIDTH-1:0] stage_q [DELAY];

    always_ff @(posedge clk) begin
      if (!reset) begin
        for (int i = 0; i < int'(DELAY); i++) stage_q[i] <= '0;
      end else begin
        stage_q[0] <= din;
        for (int i = 1; i < int'(DELAY); i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign dout = stage_q[DELAY-1];
  end

endmodule

// File: rtl/glitch_detector.sv
// Lockstep comparator: aligns the primary core word with the lagging shadow word,
// classifies divergence as OK/SUSPECT/FAULT and keeps a sticky fault for recovery logic.
module glitch_detector
  import glitch_pkg::*;
#(
  parameter int unsigned WIDTH     = DefaultWidth,
  parameter int unsigned DELAY     = 2,
  parameter int unsigned THRESHOLD = 3,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_a,
  input  logic [WIDTH-1:0] data_a,
  input  logic             valid_b,
  input  logic [WIDTH-1:0] data_b,
  input  logic             clear,
  output logic             mismatch,
  output logic             fault,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] mismatch_count,
  output logic [WIDTH-1:0] first_diff
);

  localparam int unsigned ConsecW = $clog2(THRESHOLD + 1);
  localparam logic [ConsecW-1:0] ThreshC = ConsecW'(THRESHOLD);

  logic [WIDTH:0]     a_dly;
  logic               valid_a_d;
  logic [WIDTH-1:0]   data_a_d;

  logic               mismatch_evt;
  logic               match_evt;
  logic [WIDTH-1:0]   diff;
  logic [ConsecW-1:0] consec_inc;

  state_e             state_q;
  logic               fault_q;
  logic               mismatch_q;
  logic [ConsecW-1:0] consec_q;
  logic [CNT_W-1:0]   count_q;
  logic [WIDTH-1:0]   first_diff_q;

  delay_line #(
    .WIDTH(WIDTH + 1),
    .DELAY(DELAY)
  ) u_delay (
    .clk  (clk),
    .reset(reset),
    .din  ({valid_a, data_a}),
    .dout (a_dly)
  );

  assign valid_a_d = a_dly[WIDTH];
  assign data_a_d  = a_dly[WIDTH-1:0];

  always_comb begin
    mismatch_evt = 1'b0;
    match_evt    = 1'b0;
    diff         = '0;
    if (valid_a_d && valid_b) begin
      mismatch_evt = (data_a_d != data_b);
      match_evt    = !mismatch_evt;
      diff         = data_a_d ^ data_b;
    end else if (valid_a_d || valid_b) begin
      // Valid divergence: no meaningful XOR, flag every bit.
      mismatch_evt = 1'b1;
      diff         = '1;
    end
  end

  assign consec_inc = consec_q + ConsecW'(1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StOk;
      fault_q      <= 1'b0;
      mismatch_q   <= 1'b0;
      consec_q     <= '0;
      count_q      <= '0;
      first_diff_q <= '0;
    end else if (clear) begin
      // Acknowledge wins over a same-cycle event; that event is dropped.
      state_q      <= StOk;
      fault_q      <= 1'b0;
      mismatch_q   <= 1'b0;
      consec_q     <= '0;
      count_q      <= '0;
      first_diff_q <= '0;
    end else begin
      mismatch_q <= mismatch_evt;
      if (mismatch_evt) begin
        if (count_q == '0) first_diff_q <= diff;
        if (count_q != '1) count_q <= count_q + CNT_W'(1);
      end
      case (state_q)
        StOk: begin
          if (mismatch_evt) begin
            consec_q <= ConsecW'(1);
            if (THRESHOLD == 1) begin
              state_q <= StFault;
              fault_q <= 1'b1;
            end else begin
              state_q <= StSuspect;
            end
          end
        end
        StSuspect: begin
          if (mismatch_evt) begin
            consec_q <= consec_inc;
            if (consec_inc == ThreshC) begin
              state_q <= StFault;
              fault_q <= 1'b1;
            end
          end else if (match_evt) begin
            state_q  <= StOk;
            consec_q <= '0;
          end
        end
        StFault: ;
        default: begin
          state_q  <= StOk;
          fault_q  <= 1'b0;
          consec_q <= '0;
        end
      endcase
    end
  end

  assign mismatch       = mismatch_q;
  assign fault          = fault_q;
  assign state          = state_q;
  assign mismatch_count = count_q;
  assign first_diff     = first_diff_q;

endmodule

// File: tb/tb_glitch_detector.sv
// Randomised bench for glitch_detector: three configurations share one stimulus stream
// and are checked each cycle against a history-array reference model.
module tb_glitch_detector;
  import glitch_pkg::*;

  localparam int NI = 3;

  logic       clk = 1'b0;
  logic       reset, valid_a, valid_b, clear;
  logic [7:0] data_a, data_b;

  logic       o_mis   [NI];
  logic       o_fault [NI];
  logic [1:0] o_state [NI];
  logic [7:0] o_fd    [NI];
  logic [15:0] o_cnt0, o_cnt2;
  logic [3:0]  o_cnt1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  glitch_detector #(.WIDTH(8), .DELAY(2), .THRESHOLD(3), .CNT_W(16)) u0 (
    .clk(clk), .reset(reset), .valid_a(valid_a), .data_a(data_a), .valid_b(valid_b),
    .data_b(data_b), .clear(clear), .mismatch(o_mis[0]), .fault(o_fault[0]),
    .state(o_state[0]), .mismatch_count(o_cnt0), .first_diff(o_fd[0])
  );

  glitch_detector #(.WIDTH(8), .DELAY(2), .THRESHOLD(3), .CNT_W(4)) u1 (
    .clk(clk), .reset(reset), .valid_a(valid_a), .data_a(data_a), .valid_b(valid_b),
    .data_b(data_b), .clear(clear), .mismatch(o_mis[1]), .fault(o_fault[1]),
    .state(o_state[1]), .mismatch_count(o_cnt1), .first_diff(o_fd[1])
  );

  glitch_detector #(.WIDTH(8), .DELAY(0), .THRESHOLD(1), .CNT_W(16)) u2 (
    .clk(clk), .reset(reset), .valid_a(valid_a), .data_a(data_a), .valid_b(valid_b),
    .data_b(data_b), .clear(clear), .mismatch(o_mis[2]), .fault(o_fault[2]),
    .state(o_state[2]), .mismatch_count(o_cnt2), .first_diff(o_fd[2])
  );

  // Reference model: per-configuration input history plus abstract classifier state.
  int         dly  [NI] = '{2, 2, 0};
  int         thr  [NI] = '{3, 3, 1};
  int         cmax [NI] = '{65535, 15, 65535};
  int         m_st  [NI];
  int         m_con [NI];
  int         m_cnt [NI];
  logic [7:0] m_fd  [NI];
  logic       m_mis [NI];
  logic       hv [NI][16];
  logic [7:0] hd [NI][16];

  task automatic chk(input string tag, input int k, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s[u%0d] @%0t: got %0h expected %0h", tag, k, $time, got, exp);
    end
  endtask

  function automatic logic [31:0] cnt_of(input int k);
    if (k == 0) return 32'(o_cnt0);
    if (k == 1) return 32'(o_cnt1);
    return 32'(o_cnt2);
  endfunction

  task automatic model_step();
    for (int k = 0; k < NI; k++) begin
      logic       va_d, mis, match;
      logic [7:0] da_d, dv;
      if (!reset) begin
        m_st[k] = 0; m_con[k] = 0; m_cnt[k] = 0; m_fd[k] = 8'h00; m_mis[k] = 1'b0;
        for (int j = 0; j < 16; j++) begin
          hv[k][j] = 1'b0;
          hd[k][j] = 8'h00;
        end
        continue;
      end
      va_d = (dly[k] == 0) ? valid_a : hv[k][dly[k]-1];
      da_d = (dly[k] == 0) ? data_a  : hd[k][dly[k]-1];
      mis   = (va_d != valid_b) || (va_d && valid_b && da_d != data_b);
      match = va_d && valid_b && da_d == data_b;
      dv    = (va_d && valid_b) ? (da_d ^ data_b) : 8'hFF;
      if (clear) begin
        m_st[k] = 0; m_con[k] = 0; m_cnt[k] = 0; m_fd[k] = 8'h00; m_mis[k] = 1'b0;
      end else begin
        m_mis[k] = mis;
        if (mis) begin
          if (m_cnt[k] == 0) m_fd[k] = dv;
          if (m_cnt[k] < cmax[k]) m_cnt[k]++;
        end
        if (m_st[k] == 0 && mis) begin
          m_con[k] = 1;
          m_st[k]  = (thr[k] == 1) ? 2 : 1;
        end else if (m_st[k] == 1 && mis) begin
          m_con[k]++;
          if (m_con[k] == thr[k]) m_st[k] = 2;
        end else if (m_st[k] == 1 && match) begin
          m_st[k] = 0; m_con[k] = 0;
        end
      end
      for (int j = 15; j > 0; j--) begin
        hv[k][j] = hv[k][j-1];
        hd[k][j] = hd[k][j-1];
      end
      hv[k][0] = valid_a;
      hd[k][0] = data_a;
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      chk("mismatch", k, 32'(o_mis[k]), 32'(m_mis[k]));
      chk("state", k, 32'(o_state[k]), 32'(m_st[k]));
      chk("fault", k, 32'(o_fault[k]), 32'(m_st[k] == 2));
      chk("count", k, cnt_of(k), 32'(m_cnt[k]));
      chk("first_diff", k, 32'(o_fd[k]), 32'(m_fd[k]));
    end
  endtask

  // Shadow side follows the primary stream two cycles late, optionally corrupted.
  task automatic drive(input logic va, input logic [7:0] da, input logic [7:0] corrupt,
                       input logic clr);
    valid_a = va;
    data_a  = da;
    valid_b = hv[0][1];
    data_b  = hd[0][1] ^ corrupt;
    clear   = clr;
    cycle();
  endtask

  initial begin
    reset = 1'b0; valid_a = 1'b0; valid_b = 1'b0; clear = 1'b0;
    data_a = 8'h00; data_b = 8'h00;
    repeat (2) cycle();
    reset = 1'b1;

    // Identity stream
    repeat (100) drive(1'b1, PatIdle, 8'h00, 1'b0);
    chk("id_count", 0, 32'(o_cnt0), 32'd0);
    chk("id_state", 0, 32'(o_state[0]), 32'(StOk));

    // Single glitch
    drive(1'b1, PatIdle, PatIdle ^ PatFlip, 1'b0);
    chk("glitch_pulse", 0, 32'(o_mis[0]), 32'd1);
    chk("glitch_suspect", 0, 32'(o_state[0]), 32'(StSuspect));
    drive(1'b1, PatIdle, 8'h00, 1'b0);
    chk("glitch_ok", 0, 32'(o_state[0]), 32'(StOk));
    chk("glitch_count", 0, 32'(o_cnt0), 32'd1);
    chk("glitch_fd", 0, 32'(o_fd[0]), 32'hFF);

    // Burst to fault
    drive(1'b1, PatIdle, 8'h00, 1'b1);
    repeat (3) drive(1'b1, PatIdle, 8'h01, 1'b0);
    chk("burst_fault", 0, 32'(o_fault[0]), 32'd1);
    chk("burst_fd", 0, 32'(o_fd[0]), 32'h01);
    repeat (5) drive(1'b1, PatIdle, 8'h00, 1'b0);
    chk("burst_hold", 0, 32'(o_state[0]), 32'(StFault));
    chk("burst_count", 0, 32'(o_cnt0), 32'd3);

    // Clear beats a simultaneous mismatch
    drive(1'b1, PatIdle, 8'h01, 1'b1);
    chk("clr_state", 0, 32'(o_state[0]), 32'(StOk));
    chk("clr_count", 0, 32'(o_cnt0), 32'd0);
    chk("clr_mis", 0, 32'(o_mis[0]), 32'd0);

    // Valid divergence, then idle cycles hold SUSPECT
    repeat (3) drive(1'b0, 8'h00, 8'h00, 1'b0);
    valid_a = 1'b0; valid_b = 1'b1; data_b = PatIdle; clear = 1'b0;
    cycle();
    chk("vdiv_pulse", 0, 32'(o_mis[0]), 32'd1);
    chk("vdiv_fd", 0, 32'(o_fd[0]), 32'hFF);
    repeat (3) drive(1'b0, 8'h00, 8'h00, 1'b0);
    chk("idle_hold", 0, 32'(o_state[0]), 32'(StSuspect));

    // Saturation on the 4-bit counter, then reset
    drive(1'b1, PatIdle, 8'h00, 1'b1);
    drive(1'b1, PatIdle, 8'h00, 1'b0);
    repeat (20) drive(1'b1, PatIdle, 8'h10, 1'b0);
    chk("sat_count", 1, 32'(o_cnt1), 32'd15);
    chk("wide_count", 0, 32'(o_cnt0), 32'd20);
    reset = 1'b0;
    cycle();
    for (int k = 0; k < 2; k++) begin
      chk("rst_state", k, 32'(o_state[k]), 32'(StOk));
      chk("rst_count", k, cnt_of(k), 32'd0);
      chk("rst_fd", k, 32'(o_fd[k]), 32'd0);
    end
    reset = 1'b1;

    // Random traffic
    repeat (3000) begin
      logic       va, clr;
      logic [7:0] da, cor;
      reset = ($urandom_range(0, 299) != 0);
      va    = ($urandom_range(0, 3) != 0);
      da    = 8'($urandom);
      cor   = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      clr   = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 14) == 0) begin
        valid_a = va; data_a = da; clear = clr;
        valid_b = ~hv[0][1]; data_b = 8'($urandom);
        cycle();
      end else begin
        drive(va, da, cor, clr);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
